// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS front end: word width, PC step, default reset
// PC, the fetch FSM state encoding and a saturating counter helper.
package mips_pkg;

   localparam int                WORD_W       = 32;
   localparam logic [WORD_W-1:0] PC_STEP      = 32'd4;
   localparam logic [WORD_W-1:0] RESET_PC_DEF = 32'h0000_0000;

   typedef enum logic {
      FS_IDLE,
      FS_RUN
   } fetch_state_t;

   // Add without wrapping; sticks at all-ones once the counter tops out.
   function automatic logic [31:0] sat_add32(input logic [31:0] a, input logic [31:0] b);
      logic [32:0] sum;
      sum = {1'b0, a} + {1'b0, b};
      return sum[32] ? 32'hFFFF_FFFF : sum[31:0];
   endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO used twice by the fetch stage: once for {pc, instr}
// pairs waiting for decode and once as the in-order tag queue of issued
// addresses. DEPTH must be a power of two so the pointers wrap for free.
// Flush empties the FIFO and wins over a same-cycle push or pop; a push and a
// pop together on a full FIFO are accepted and leave the count unchanged.
module fetch_fifo
   import mips_pkg::*;
#(
   parameter int W     = 2 * WORD_W,
   parameter int DEPTH = 4
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   push,
   input  logic                   pop,
   input  logic                   flush,
   input  logic [W-1:0]           wdata,
   output logic [W-1:0]           rdata,
   output logic [$clog2(DEPTH):0] count,
   output logic                   full,
   output logic                   empty
);

   localparam int AW = $clog2(DEPTH);

   logic [W-1:0]  mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic          do_push;
   logic          do_pop;

   assign full    = (count == (AW+1)'(DEPTH));
   assign empty   = (count == '0);
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);
   assign rdata   = mem[rd_ptr];

   // Pointer and occupancy bookkeeping; flush drops every entry at once.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
      end
   end

   // Storage needs no reset: an entry is only read after it has been written.
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= wdata;
   end

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage of the 5-stage MIPS pipeline. Owns the PC, issues word reads to
// instruction memory under a credit scheme (in-flight requests plus buffered
// words never exceed DEPTH), buffers returned words and hands {pc, pc+4,
// instr} to decode with valid/ready. A redirect flushes the buffer, repoints
// the PC and marks every still-in-flight response for discard.
// Optional build macro IFETCH_PERF_EN adds saturating performance counters.
module instr_fetch_unit
   import mips_pkg::*;
#(
   parameter int               WIDTH    = WORD_W,
   parameter int               DEPTH    = 4,
   parameter int               MAX_OUT  = 2,
   parameter logic [WIDTH-1:0] RESET_PC = WIDTH'(RESET_PC_DEF)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             redirect_i,
   input  logic [WIDTH-1:0] target_i,
   output logic             imem_req_o,
   output logic [WIDTH-1:0] imem_addr_o,
   input  logic             imem_gnt_i,
   input  logic             imem_rvalid_i,
   input  logic [WIDTH-1:0] imem_rdata_i,
   output logic             valid_o,
   input  logic             ready_i,
   output logic [WIDTH-1:0] instr_o,
   output logic [WIDTH-1:0] pc_o,
   output logic [WIDTH-1:0] pc_inc_o
`ifdef IFETCH_PERF_EN
   ,output logic [31:0]     perf_fetched_o,
   output logic [31:0]      perf_stall_o,
   output logic [31:0]      perf_squash_o
`endif
);

   localparam int               CW   = $clog2(DEPTH) + 1;
   localparam logic [WIDTH-1:0] STEP = WIDTH'(PC_STEP);

   fetch_state_t     state;
   fetch_state_t     state_next;
   logic [WIDTH-1:0] fetch_pc;
   logic [CW-1:0]    discard;

   logic [2*WIDTH-1:0] d_head;
   logic [CW-1:0]      d_count;
   logic               d_full;
   logic               d_empty;
   logic [WIDTH-1:0]   t_head;
   logic [CW-1:0]      t_count;
   logic               t_full;
   logic               t_empty;

   logic             grant;
   logic             resp_push;
   logic             pop;
   logic             credit_ok;
   logic [CW:0]      reserved;
   logic [WIDTH-1:0] head_pc;

   // The tag queue holds one entry per in-flight request, so its count is
   // the outstanding count, stale requests included.
   assign grant     = imem_req_o && imem_gnt_i;
   assign resp_push = imem_rvalid_i && !redirect_i && (discard == '0);
   assign pop       = valid_o && ready_i && !redirect_i;
   assign reserved  = {1'b0, t_count} + {1'b0, d_count};
   assign credit_ok = !t_full && !d_full && (reserved < (CW+1)'(DEPTH))
                      && (t_count < CW'(MAX_OUT));

   fetch_fifo #(.W(WIDTH), .DEPTH(DEPTH)) u_tag_q (
      .clk   (clk),
      .rst   (rst),
      .push  (grant),
      .pop   (imem_rvalid_i && !t_empty),
      .flush (1'b0),
      .wdata (fetch_pc),
      .rdata (t_head),
      .count (t_count),
      .full  (t_full),
      .empty (t_empty)
   );

   fetch_fifo #(.W(2*WIDTH), .DEPTH(DEPTH)) u_data_q (
      .clk   (clk),
      .rst   (rst),
      .push  (resp_push),
      .pop   (pop),
      .flush (redirect_i),
      .wdata ({t_head, imem_rdata_i}),
      .rdata (d_head),
      .count (d_count),
      .full  (d_full),
      .empty (d_empty)
   );

   // Fetch FSM state register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= FS_IDLE;
      else      state <= state_next;
   end

   // Next state follows start; requests only go out while running with credit.
   always_comb begin
      state_next = state;
      imem_req_o = 1'b0;
      case (state)
         FS_IDLE: begin
            if (start) state_next = FS_RUN;
         end
         FS_RUN: begin
            imem_req_o = credit_ok;
            if (!start) state_next = FS_IDLE;
         end
         default: state_next = FS_IDLE;
      endcase
   end

   // PC advances on each accepted request; a redirect overrides it.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)            fetch_pc <= RESET_PC;
      else if (redirect_i) fetch_pc <= target_i;
      else if (grant)      fetch_pc <= fetch_pc + STEP;
   end

   // On redirect every response still in flight after this cycle is stale.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         discard <= '0;
      else if (redirect_i)
         discard <= t_count + CW'(grant) - CW'(imem_rvalid_i);
      else if (imem_rvalid_i && (discard != '0))
         discard <= discard - 1'b1;
   end

   assign head_pc     = d_head[2*WIDTH-1:WIDTH];
   assign valid_o     = !d_empty;
   assign imem_addr_o = imem_req_o ? fetch_pc : '0;
   assign pc_o        = valid_o ? head_pc : '0;
   assign instr_o     = valid_o ? d_head[WIDTH-1:0] : '0;
   assign pc_inc_o    = valid_o ? head_pc + STEP : '0;

`ifdef IFETCH_PERF_EN
   logic [31:0] squash_inc;

   // Squashed words this cycle: flushed entries plus any dropped response.
   always_comb begin
      squash_inc = 32'd0;
      if (redirect_i)
         squash_inc = 32'(d_count) + 32'(imem_rvalid_i);
      else if (imem_rvalid_i && (discard != '0))
         squash_inc = 32'd1;
   end

   // Saturating event counters for pops, decode stalls and squashed words.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         perf_fetched_o <= 32'd0;
         perf_stall_o   <= 32'd0;
         perf_squash_o  <= 32'd0;
      end else begin
         perf_fetched_o <= sat_add32(perf_fetched_o, 32'(pop));
         perf_stall_o   <= sat_add32(perf_stall_o, 32'(valid_o && !ready_i));
         perf_squash_o  <= sat_add32(perf_squash_o, squash_inc);
      end
   end
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Testbench for instr_fetch_unit: an in-order instruction memory model with
// configurable latency, a queue-based reference model of the fetch stage that
// is compared against every output each cycle, and directed scenarios with
// hand-computed expectations (fill, stall, redirects, wrap, start drop, reset).
module tb_instr_fetch_unit;

   localparam int          WIDTH    = 32;
   localparam int          DEPTH    = 4;
   localparam int          MAX_OUT  = 2;
   localparam logic [31:0] RESET_PC = 32'h0000_0000;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        start = 1'b0;
   logic        redirect_i = 1'b0;
   logic [31:0] target_i = 32'h0;
   logic        imem_gnt_i = 1'b0;
   logic        imem_rvalid_i = 1'b0;
   logic [31:0] imem_rdata_i = 32'h0;
   logic        ready_i = 1'b0;
   logic        imem_req_o;
   logic [31:0] imem_addr_o;
   logic        valid_o;
   logic [31:0] instr_o;
   logic [31:0] pc_o;
   logic [31:0] pc_inc_o;
`ifdef IFETCH_PERF_EN
   logic [31:0] perf_fetched_o;
   logic [31:0] perf_stall_o;
   logic [31:0] perf_squash_o;
`endif

   always #5 clk = ~clk;

   instr_fetch_unit #(
      .WIDTH    (WIDTH),
      .DEPTH    (DEPTH),
      .MAX_OUT  (MAX_OUT),
      .RESET_PC (RESET_PC)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .start         (start),
      .redirect_i    (redirect_i),
      .target_i      (target_i),
      .imem_req_o    (imem_req_o),
      .imem_addr_o   (imem_addr_o),
      .imem_gnt_i    (imem_gnt_i),
      .imem_rvalid_i (imem_rvalid_i),
      .imem_rdata_i  (imem_rdata_i),
      .valid_o       (valid_o),
      .ready_i       (ready_i),
      .instr_o       (instr_o),
      .pc_o          (pc_o),
      .pc_inc_o      (pc_inc_o)
`ifdef IFETCH_PERF_EN
      ,.perf_fetched_o (perf_fetched_o),
      .perf_stall_o    (perf_stall_o),
      .perf_squash_o   (perf_squash_o)
`endif
   );

   typedef struct { logic [31:0] addr; int due; } mem_req_t;
   typedef struct { logic [31:0] addr; bit stale; } flight_t;
   typedef struct { logic [31:0] pc; logic [31:0] instr; } entry_t;

   mem_req_t    mem_q[$];
   flight_t     m_flight[$];
   entry_t      m_fifo[$];
   bit          m_running;
   logic [31:0] m_pc;
   int          m_fetched;
   int          m_stalls;
   int          m_squash;

   logic [31:0] pop_pc[$];
   logic [31:0] pop_inc[$];
   logic [31:0] pop_instr[$];
   logic [31:0] pop_cyc[$];

   int lat;
   int cyc;
   int grants;
   int tests;
   int errors;

   function automatic logic [31:0] mem_word(input logic [31:0] addr);
      return addr ^ 32'hDEAD_BEEF;
   endfunction

   function automatic logic [31:0] q_at(input logic [31:0] q[$], input int i);
      if (i < q.size()) return q[i];
      return 32'hBAD0_BAD0;
   endfunction

   function automatic bit model_req();
      return m_running && (m_flight.size() + m_fifo.size() < DEPTH) && (m_flight.size() < MAX_OUT);
   endfunction

   function automatic bit model_valid();
      return m_fifo.size() != 0;
   endfunction

   task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic check_output();
      logic [31:0] e_pc;
      logic [31:0] e_instr;
      logic [31:0] e_inc;
      e_pc = 32'h0; e_instr = 32'h0; e_inc = 32'h0;
      if (model_valid()) begin
         e_pc    = m_fifo[0].pc;
         e_instr = m_fifo[0].instr;
         e_inc   = m_fifo[0].pc + 32'd4;
      end
      check32("imem_req_o", 32'(imem_req_o), 32'(model_req()));
      check32("imem_addr_o", imem_addr_o, model_req() ? m_pc : 32'h0);
      check32("valid_o", 32'(valid_o), 32'(model_valid()));
      check32("instr_o", instr_o, e_instr);
      check32("pc_o", pc_o, e_pc);
      check32("pc_inc_o", pc_inc_o, e_inc);
`ifdef IFETCH_PERF_EN
      check32("perf_fetched_o", perf_fetched_o, 32'(m_fetched));
      check32("perf_stall_o", perf_stall_o, 32'(m_stalls));
      check32("perf_squash_o", perf_squash_o, 32'(m_squash));
`endif
   endtask

   // One clock cycle: present the memory response, check mid-cycle, then
   // advance memory and reference model with what happened at the edge.
   task automatic apply_stimulus();
      bit          e_req, e_valid, s_rv, s_grant, s_redir, s_ready, s_start, s_dpop;
      logic [31:0] s_addr, s_target;
      flight_t     f;
      imem_rvalid_i = (mem_q.size() > 0) && (mem_q[0].due <= cyc);
      imem_rdata_i  = imem_rvalid_i ? mem_word(mem_q[0].addr) : $urandom();
      @(negedge clk);
      check_output();
      e_req    = model_req();
      e_valid  = model_valid();
      s_rv     = imem_rvalid_i;
      s_grant  = imem_req_o && imem_gnt_i;
      s_addr   = imem_addr_o;
      s_redir  = redirect_i;
      s_target = target_i;
      s_ready  = ready_i;
      s_start  = start;
      s_dpop   = valid_o && ready_i && !redirect_i;
      if (s_dpop) begin
         pop_pc.push_back(pc_o);
         pop_inc.push_back(pc_inc_o);
         pop_instr.push_back(instr_o);
         pop_cyc.push_back(32'(cyc));
      end
      @(posedge clk);
      #1;
      if (s_rv && mem_q.size() > 0) void'(mem_q.pop_front());
      if (s_grant) begin
         mem_q.push_back('{s_addr, cyc + lat});
         grants++;
      end
      if (e_valid && !s_ready) m_stalls++;
      if (s_redir) begin
         m_squash += m_fifo.size() + (s_rv ? 1 : 0);
         m_fifo.delete();
         if (s_rv && m_flight.size() > 0) void'(m_flight.pop_front());
         foreach (m_flight[i]) m_flight[i].stale = 1'b1;
         if (e_req && imem_gnt_i) m_flight.push_back('{m_pc, 1'b1});
         m_pc = s_target;
      end else begin
         if (e_valid && s_ready) begin
            void'(m_fifo.pop_front());
            m_fetched++;
         end
         if (s_rv && m_flight.size() > 0) begin
            f = m_flight.pop_front();
            if (f.stale) m_squash++;
            else         m_fifo.push_back('{f.addr, mem_word(f.addr)});
         end
         if (e_req && imem_gnt_i) begin
            m_flight.push_back('{m_pc, 1'b0});
            m_pc = m_pc + 32'd4;
         end
      end
      m_running  = s_start;
      redirect_i = 1'b0;
      cyc++;
   endtask

   // Asynchronous reset, possibly in the middle of traffic; outputs must drop at once.
   task automatic do_reset();
      rst           = 1'b0;
      start         = 1'b0;
      redirect_i    = 1'b0;
      imem_rvalid_i = 1'b0;
      mem_q.delete();
      m_flight.delete();
      m_fifo.delete();
      m_running = 1'b0;
      m_pc      = RESET_PC;
      m_fetched = 0;
      m_stalls  = 0;
      m_squash  = 0;
      #1;
      check32("reset_req", 32'(imem_req_o), 32'h0);
      check32("reset_addr", imem_addr_o, 32'h0);
      check32("reset_valid", 32'(valid_o), 32'h0);
      check32("reset_instr", instr_o, 32'h0);
      check32("reset_pc", pc_o, 32'h0);
      check32("reset_pc_inc", pc_inc_o, 32'h0);
`ifdef IFETCH_PERF_EN
      check32("reset_perf_fetched", perf_fetched_o, 32'h0);
`endif
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b1;
      cyc = 0;
      grants = 0;
      pop_pc.delete();
      pop_inc.delete();
      pop_instr.delete();
      pop_cyc.delete();
   endtask

   initial begin
      #100000;
      $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int bad;
      tests = 0; errors = 0; lat = 1; cyc = 0; grants = 0;
      imem_gnt_i = 1'b1;
      ready_i    = 1'b1;

      // Fill from reset: one word per cycle once the pipe is primed.
      do_reset();
      start = 1'b1;
      repeat (8) apply_stimulus();
      check32("fill_pc0", q_at(pop_pc, 0), 32'h0);
      check32("fill_pc1", q_at(pop_pc, 1), 32'h4);
      check32("fill_pc2", q_at(pop_pc, 2), 32'h8);
      check32("fill_pc3", q_at(pop_pc, 3), 32'hC);
      check32("fill_cyc0", q_at(pop_cyc, 0), 32'd3);
      check32("fill_cyc3", q_at(pop_cyc, 3), 32'd6);
      check32("fill_inc0", q_at(pop_inc, 0), 32'h4);
      check32("fill_instr0", q_at(pop_instr, 0), 32'hDEAD_BEEF);

      // Decode stall: credits allow exactly DEPTH requests, head held.
      do_reset();
      ready_i = 1'b0;
      start   = 1'b1;
      repeat (10) apply_stimulus();
      check32("stall_grants", 32'(grants), 32'd4);
      check32("stall_req_low", 32'(imem_req_o), 32'h0);
      check32("stall_valid", 32'(valid_o), 32'h1);
      check32("stall_pc_held", pc_o, 32'h0);
      check32("stall_instr_held", instr_o, 32'hDEAD_BEEF);
      check32("stall_no_pops", 32'(pop_pc.size()), 32'd0);
      ready_i = 1'b1;
      repeat (6) apply_stimulus();
      check32("drain_pc0", q_at(pop_pc, 0), 32'h0);
      check32("drain_pc3", q_at(pop_pc, 3), 32'hC);
      check32("drain_cyc0", q_at(pop_cyc, 0), 32'd10);
      check32("drain_cyc3", q_at(pop_cyc, 3), 32'd13);

      // Redirect with two requests outstanding at 3-cycle latency.
      do_reset();
      lat   = 3;
      start = 1'b1;
      repeat (11) apply_stimulus();
      check32("redir_pops_before", 32'(pop_pc.size()), 32'd4);
      check32("redir_req_before", 32'(imem_req_o), 32'h0);
      redirect_i = 1'b1;
      target_i   = 32'h100;
      apply_stimulus();
      repeat (8) apply_stimulus();
      check32("redir_next_pc", q_at(pop_pc, 4), 32'h100);
      check32("redir_next_cyc", q_at(pop_cyc, 4), 32'd17);
      bad = 0;
      foreach (pop_pc[i]) if (pop_pc[i] == 32'h10 || pop_pc[i] == 32'h14) bad++;
      check32("redir_stale_seen", 32'(bad), 32'd0);

      // Redirect coinciding with a response and a grant.
      do_reset();
      lat   = 1;
      start = 1'b1;
      repeat (4) apply_stimulus();
      redirect_i = 1'b1;
      target_i   = 32'h200;
      apply_stimulus();
      repeat (5) apply_stimulus();
      check32("same_cyc_pc0", q_at(pop_pc, 0), 32'h0);
      check32("same_cyc_pc1", q_at(pop_pc, 1), 32'h200);
      check32("same_cyc_cyc1", q_at(pop_cyc, 1), 32'd7);
`ifdef IFETCH_PERF_EN
      check32("same_cyc_squash", perf_squash_o, 32'd3);
`endif

      // Redirect while idle, then PC wrap-around.
      do_reset();
      redirect_i = 1'b1;
      target_i   = 32'hFFFF_FFFC;
      apply_stimulus();
      repeat (3) apply_stimulus();
      check32("idle_no_grants", 32'(grants), 32'd0);
      start = 1'b1;
      repeat (6) apply_stimulus();
      check32("wrap_pc0", q_at(pop_pc, 0), 32'hFFFF_FFFC);
      check32("wrap_inc0", q_at(pop_inc, 0), 32'h0);
      check32("wrap_pc1", q_at(pop_pc, 1), 32'h0);
      check32("wrap_cyc0", q_at(pop_cyc, 0), 32'd7);

      // start dropped with two requests in flight.
      do_reset();
      lat   = 3;
      start = 1'b1;
      repeat (3) apply_stimulus();
      start = 1'b0;
      repeat (8) apply_stimulus();
      check32("stop_grants", 32'(grants), 32'd2);
      check32("stop_pops", 32'(pop_pc.size()), 32'd2);
      check32("stop_pc1", q_at(pop_pc, 1), 32'h4);
      check32("stop_valid_end", 32'(valid_o), 32'h0);
`ifdef IFETCH_PERF_EN
      check32("stop_perf_fetched", perf_fetched_o, 32'd2);
`endif

      // Reset in the middle of traffic, then a clean restart from RESET_PC.
      start = 1'b1;
      repeat (3) apply_stimulus();
      do_reset();
      start = 1'b1;
      repeat (7) apply_stimulus();
      check32("restart_pc0", q_at(pop_pc, 0), 32'h0);
      check32("restart_cyc0", q_at(pop_cyc, 0), 32'd5);

      $display("[TB] %0d tests run, %0d failed", tests, errors);
      $finish;
   end

endmodule
